// File: rtl/offset_serializer.sv
// Splits a 32-bit word into four 8-bit lanes over valid/ready handshakes.
// All storage and ports use offset (LSB=1) ranges for frontend slicing coverage.
module offset_serializer #(
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [32:1]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [8:1]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [2:1]       out_idx,
    output logic [CNT_W:1]   word_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [32:1]      word_r;
    logic [32:1]      word_s;
    logic [2:1]       beat_r;
    logic [2:1]       beat_s;
    logic [CNT_W:1]   cnt_r;
    logic [CNT_W:1]   cnt_s;
    logic [2:1]       lane_s;

    // Pick byte lane k of the shadow word using offset part-selects.
    function automatic logic [8:1] lane_sel(input logic [32:1] w, input logic [2:1] k);
        logic [8:1] r;
        case (k)
            2'd0:    r = w[8:1];
            2'd1:    r = w[16:9];
            2'd2:    r = w[24:17];
            2'd3:    r = w[32:25];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // State, shadow word, beat counter and completed-word counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            word_r  <= 32'h0000_0000;
            beat_r  <= 2'd0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            word_r  <= word_s;
            beat_r  <= beat_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: accept only from IDLE, advance beats on handshakes.
    always_comb begin
        state_s = state_r;
        word_s  = word_r;
        beat_s  = beat_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    word_s  = in_data;
                    beat_s  = 2'd0;
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (beat_r == 2'd3) begin
                        state_s = IDLE;
                        beat_s  = 2'd0;
                        cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        beat_s  = beat_r + 2'd1;
                    end
                end else begin
                    beat_s = beat_r;
                end
            end
            default: begin
                state_s = IDLE;
                beat_s  = 2'd0;
            end
        endcase
    end

    // Output decode straight from registered state so outputs stay glitch-free across holds.
    always_comb begin
        lane_s    = MSB_FIRST ? (2'd3 - beat_r) : beat_r;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_idx   = 2'd0;
        out_data  = 8'h00;
        if (state_r == SEND) begin
            out_valid = 1'b1;
            out_idx   = beat_r;
            out_last  = (beat_r == 2'd3);
            out_data  = lane_sel(word_r, lane_s);
        end else begin
            in_ready  = 1'b1;
        end
    end

    assign word_cnt = cnt_r;

endmodule

// File: tb/tb_offset_serializer.sv
// Directed bench: LSB-first and MSB-first instances plus a narrow-counter instance for wrap.
module tb_offset_serializer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [32:1] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_last0;
    logic [8:1]  out_data0;
    logic [2:1]  out_idx0;
    logic [16:1] word_cnt0;

    logic        in_ready1, out_valid1, out_last1;
    logic [8:1]  out_data1;
    logic [2:1]  out_idx1;
    logic [16:1] word_cnt1;

    logic        in_ready2, out_valid2, out_last2;
    logic [8:1]  out_data2;
    logic [2:1]  out_idx2;
    logic [4:1]  word_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    offset_serializer #(.MSB_FIRST(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_last(out_last0), .out_idx(out_idx0), .word_cnt(word_cnt0)
    );

    offset_serializer #(.MSB_FIRST(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_last(out_last1), .out_idx(out_idx1), .word_cnt(word_cnt1)
    );

    offset_serializer #(.MSB_FIRST(1'b0), .CNT_W(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready), .out_last(out_last2), .out_idx(out_idx2), .word_cnt(word_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0000_0000;
        out_ready = 1'b1;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic send_word(input logic [32:1] w);
        in_data  = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0000_0000;
        out_ready = 1'b1;
        repeat (2) step();
        checks++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || out_last0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b last=%b exp rdy=1 vld=0 last=0", in_ready0, out_valid0, out_last0);
        end
        checks++;
        if (out_idx0 !== 2'd0 || out_data0 !== 8'h00 || word_cnt0 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data got idx=%0d data=%h cnt=%h exp 0 00 0000", out_idx0, out_data0, word_cnt0);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_order();
        logic [8:1] lsb [4];
        logic [8:1] msb [4];
        lsb = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        msb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        in_data   = 32'hA1B2_C3D4;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_data0 !== lsb[i] || out_idx0 !== 2'(i) || out_last0 !== (i == 3) || out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
                errors++;
                $display("FAIL lsb_beat%0d got data=%h idx=%0d last=%b vld=%b rdy=%b exp data=%h idx=%0d last=%b vld=1 rdy=0",
                         i, out_data0, out_idx0, out_last0, out_valid0, in_ready0, lsb[i], i, (i == 3));
            end
            checks++;
            if (out_data1 !== msb[i] || out_idx1 !== 2'(i) || out_last1 !== (i == 3)) begin
                errors++;
                $display("FAIL msb_beat%0d got data=%h idx=%0d last=%b exp data=%h idx=%0d last=%b",
                         i, out_data1, out_idx1, out_last1, msb[i], i, (i == 3));
            end
            step();
        end
        checks++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || word_cnt0 !== 16'd1 || word_cnt1 !== 16'd1) begin
            errors++;
            $display("FAIL order_done got rdy=%b vld=%b cnt0=%0d cnt1=%0d exp rdy=1 vld=0 cnt=1", in_ready0, out_valid0, word_cnt0, word_cnt1);
        end
    endtask

    task automatic test_backpressure();
        in_data   = 32'hA1B2_C3D4;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_data0 !== 8'hD4 || out_idx0 !== 2'd0) begin
            errors++;
            $display("FAIL bp_beat0 got data=%h idx=%0d exp d4 0", out_data0, out_idx0);
        end
        step();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (out_data0 !== 8'hC3 || out_idx0 !== 2'd1 || out_valid0 !== 1'b1 || out_last0 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got data=%h idx=%0d vld=%b last=%b exp c3 1 1 0", j, out_data0, out_idx0, out_valid0, out_last0);
            end
            if (j == 2) out_ready = 1'b1;
            step();
        end
        checks++;
        if (out_data0 !== 8'hB2 || out_idx0 !== 2'd2) begin
            errors++;
            $display("FAIL bp_beat2 got data=%h idx=%0d exp b2 2", out_data0, out_idx0);
        end
        step();
        checks++;
        if (out_data0 !== 8'hA1 || out_idx0 !== 2'd3 || out_last0 !== 1'b1) begin
            errors++;
            $display("FAIL bp_beat3 got data=%h idx=%0d last=%b exp a1 3 1", out_data0, out_idx0, out_last0);
        end
        step();
        checks++;
        if (word_cnt0 !== 16'd2 || out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL bp_done got cnt=%0d vld=%b exp 2 0", word_cnt0, out_valid0);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:1] exp1 [4];
        logic [8:1] exp2 [4];
        exp1 = '{8'h01, 8'h00, 8'h00, 8'h00};
        exp2 = '{8'h00, 8'h00, 8'h00, 8'h80};
        apply_reset();
        in_data  = 32'h0000_0001;
        in_valid = 1'b1;
        step();
        in_data = 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_data0 !== exp1[i] || in_ready0 !== 1'b0 || out_idx0 !== 2'(i)) begin
                errors++;
                $display("FAIL b2b_w1_beat%0d got data=%h rdy=%b idx=%0d exp data=%h rdy=0 idx=%0d", i, out_data0, in_ready0, out_idx0, exp1[i], i);
            end
            step();
        end
        checks++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got rdy=%b vld=%b exp rdy=1 vld=0", in_ready0, out_valid0);
        end
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_data0 !== exp2[i] || out_idx0 !== 2'(i) || out_valid0 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_w2_beat%0d got data=%h idx=%0d vld=%b exp data=%h idx=%0d vld=1", i, out_data0, out_idx0, out_valid0, exp2[i], i);
            end
            step();
        end
        checks++;
        if (word_cnt0 !== 16'd2) begin
            errors++;
            $display("FAIL b2b_cnt got %0d exp 2", word_cnt0);
        end
    endtask

    task automatic test_async_reset();
        in_data   = 32'hA1B2_C3D4;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        checks++;
        if (out_idx0 !== 2'd2 || out_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre got idx=%0d vld=%b exp 2 1", out_idx0, out_valid0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || word_cnt0 !== 16'd0 || out_data0 !== 8'h00) begin
            errors++;
            $display("FAIL ar_now got vld=%b rdy=%b cnt=%0d data=%h exp 0 1 0 00", out_valid0, in_ready0, word_cnt0, out_data0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if (out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL ar_release got vld=%b exp 0", out_valid0);
        end
        in_data  = 32'h1122_3344;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_idx0 !== 2'd0 || out_data0 !== 8'h44 || out_data1 !== 8'h11) begin
            errors++;
            $display("FAIL ar_restart got idx=%0d data0=%h data1=%h exp 0 44 11", out_idx0, out_data0, out_data1);
        end
        repeat (4) step();
        checks++;
        if (word_cnt0 !== 16'd1) begin
            errors++;
            $display("FAIL ar_cnt got %0d exp 1", word_cnt0);
        end
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 14; n++) send_word(32'(n));
        checks++;
        if (word_cnt2 !== 4'hF) begin
            errors++;
            $display("FAIL wrap_pre got %h exp f", word_cnt2);
        end
        send_word(32'hDEAD_BEEF);
        checks++;
        if (word_cnt2 !== 4'h0 || word_cnt0 !== 16'd16) begin
            errors++;
            $display("FAIL wrap got cnt2=%h cnt0=%0d exp cnt2=0 cnt0=16", word_cnt2, word_cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
